stream_mux_arbiter: RTL and testbench
=====================================

Name: stream_mux_arbiter

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Two modes. In address-select mode the channel is picked by `sel`, which generalises the 4:1 address mux. In round-robin mode, pending channels are arbitrated fairly.
- Sits between multiple producers and one shared consumer (e.g. a bus or register-file write port).
- One-cycle registered latency. Full throughput of one word per cycle.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, width of `sel` and `out_channel`. Must equal max(1, ceil(log2(CHANNELS))).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = address-select, 1 = round-robin.
- sel  input  SEL_W  channel select; used only when mode=0.
- in_data  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready (combinational).
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_channel  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`; it is sampled only on the rising edge of clk.
- Reset values:
  - out_valid=0, out_data=0, out_channel=0.
  - Round-robin pointer rr_last=CHANNELS-1, so channel 0 has first priority after reset.
- Reset asserted mid-transfer discards the buffered word. No in_ready is asserted in a cycle where reset=1.
- Load condition: can_load = !out_valid || out_ready. The single output register accepts a new word when empty or when it is being drained in the same cycle.
- Grant (combinational, at most one channel):
  - mode=0: grant=sel if sel<CHANNELS and in_valid[sel]=1; otherwise no grant. Other channels are never granted, even if valid.
  - mode=1: scan channels rr_last+1, rr_last+2, ... modulo CHANNELS. The first channel with in_valid=1 is granted. No grant if all in_valid=0.
- in_ready[i] = (grant==i) && can_load && !reset. All other in_ready bits are 0.
- Transfer on a channel = in_valid[i] && in_ready[i] at a rising edge. On transfer:
  - out_data <= that channel's word, out_channel <= i, out_valid <= 1.
  - In mode=1 only, rr_last <= i.
- Drain without refill (out_valid && out_ready and no grant): out_valid <= 0. out_data and out_channel hold their last values.
- Backpressure (out_valid && !out_ready): out_data, out_channel and out_valid hold stable. All in_ready=0.
- Simultaneous drain and load in one cycle: the new word replaces the old with no bubble. Sustained throughput is 1 word/cycle with out_ready=1.
- Latency: an input accepted at edge k appears on out_data/out_valid immediately after edge k.
- Mode or sel changes take effect on the next grant evaluation. A word already buffered is unaffected.
- rr_last is not modified in mode=0, so round-robin resumes from its previous position when mode returns to 1.
- Input rules:
  - Producers may drop in_valid without transfer; no state is kept per channel.
  - No combinational path exists from in_valid to out_valid.
  - The only combinational path from out_ready to in_ready is through can_load.

Test Plan:
- Reset, then all in_valid=0, out_ready=1 for 5 cycles -> out_valid=0, out_data=0, out_channel=0, in_ready=0000 every cycle.
- mode=0, out_ready=1, all in_valid=1, in_data={8'h33,8'h22,8'h11,8'h00}, sel stepped 0..3 one per cycle -> out_data sequence 00,11,22,33 with out_channel 0,1,2,3, each one cycle after its sel. Only in_ready[sel]=1.
- mode=1, all four in_valid=1, out_ready=1 for 8 cycles -> out_channel 0,1,2,3,0,1,2,3 with no bubbles. Then with only channels 1 and 3 valid -> alternates 1,3,1,3.
- mode=1, load word 8'hA5 from channel 2, then out_ready=0 for 4 cycles -> out_data=A5, out_channel=2, out_valid=1 held, in_ready=0000. Raising out_ready drains A5 and loads the next granted word in the same cycle.
- CHANNELS=3, SEL_W=2, mode=0, sel=3, all valid -> no grant, in_ready=000, out_valid stays 0.
- Reset pulsed while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0. The next round-robin grant goes to channel 0.

Source files
------------

// File: rtl/stream_mux_arbiter.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// Channel choice is either address-selected by sel or round-robin arbitrated.
module stream_mux_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_channel
);

    logic [SEL_W-1:0] rr_last;
    logic             can_load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign can_load = !out_valid || out_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!mode) begin
            // Out-of-range sel values match no channel, so they never grant.
            for (int c = 0; c < CHANNELS; c++) begin
                if (sel == SEL_W'(c) && in_valid[c]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SEL_W'(c);
                end
            end
        end else begin
            // Scan outward from the channel after the last round-robin winner.
            for (int k = 1; k <= CHANNELS; k++) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (!grant_valid && in_valid[c] &&
                        c == (int'(rr_last) + k) % int'(CHANNELS)) begin
                        grant_valid = 1'b1;
                        grant_idx   = SEL_W'(c);
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_idx == SEL_W'(c)) begin
                grant_data = in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_ready[c] = grant_valid && (grant_idx == SEL_W'(c)) && can_load && !reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            rr_last     <= SEL_W'(CHANNELS - 1);
        end else if (can_load) begin
            if (grant_valid) begin
                out_valid   <= 1'b1;
                out_data    <= grant_data;
                out_channel <= grant_idx;
                if (mode) begin
                    rr_last <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Self-checking bench for stream_mux_arbiter: directed scenarios plus random traffic,
// all compared against a transaction-level reference model.
module tb_stream_mux_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_channel;

    // Three-channel instance for the out-of-range select case
    logic            d3_mode;
    logic [1:0]      d3_sel;
    logic [3*W-1:0]  d3_data;
    logic [2:0]      d3_valid;
    logic [2:0]      d3_ready;
    logic [W-1:0]    d3_out;
    logic            d3_ov;
    logic [1:0]      d3_ch;

    stream_mux_arbiter #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .sel         (sel),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_channel (out_channel)
    );

    stream_mux_arbiter #(.WIDTH(W), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .mode        (d3_mode),
        .sel         (d3_sel),
        .in_data     (d3_data),
        .in_valid    (d3_valid),
        .in_ready    (d3_ready),
        .out_data    (d3_out),
        .out_valid   (d3_ov),
        .out_ready   (out_ready),
        .out_channel (d3_ch)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: the one-word output buffer and the last round-robin winner
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_chan  = 0;
    int           m_last  = N - 1;

    function automatic int ref_grant();
        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic cycle();
        int           g;
        logic         cl;
        logic [N-1:0] er;
        #1;
        g  = ref_grant();
        cl = !m_valid || out_ready;
        er = '0;
        if (g >= 0 && cl && !reset) er[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_last  = N - 1;
        end else if (cl) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_chan  = g;
                if (mode) m_last = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_channel", 32'(out_channel), 32'(m_chan));
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        d3_mode   = 1'b0;
        d3_sel    = 2'd3;
        d3_data   = 24'hCC_BB_AA;
        d3_valid  = 3'b111;
        cycle();
        cycle();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_valid", 32'(out_valid), 32'(0));
            chk("idle_ready", 32'(in_ready), 32'(0));
        end

        // Address-select stepping
        in_valid = 4'b1111;
        in_data  = 32'h33221100;
        for (int s = 0; s < 4; s++) begin
            sel = SW'(s);
            cycle();
            chk("sel_data", 32'(out_data), 32'(8'h11 * s));
            chk("sel_chan", 32'(out_channel), 32'(s));
        end

        // Round-robin over all channels, then over channels 1 and 3
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rr_all_chan", 32'(out_channel), 32'(i % 4));
            chk("rr_all_valid", 32'(out_valid), 32'(1));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_13_chan", 32'(out_channel), 32'((i % 2) ? 3 : 1));
        end

        // Backpressure hold with A5 from channel 2
        in_valid = 4'b0100;
        in_data  = 32'h00A50000;
        cycle();
        chk("bp_load", 32'(out_channel), 32'(2));
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_hold_data", 32'(out_data), 32'(8'hA5));
            chk("bp_hold_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_refill_chan", 32'(out_channel), 32'(3));
        chk("bp_refill_data", 32'(out_data), 32'(8'h44));

        // Three-channel instance: sel=3 must never grant
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("c3_ready", 32'(d3_ready), 32'(0));
            chk("c3_valid", 32'(d3_ov), 32'(0));
        end
        d3_sel = 2'd2;
        @(negedge clk);
        chk("c3_sel2_ready", 32'(d3_ready), 32'(3'b100));
        @(negedge clk);
        chk("c3_sel2_data", 32'(d3_out), 32'(8'hCC));
        @(posedge clk);
        #1;

        // Reset during backpressure discards the word, round-robin restarts at 0
        in_valid  = 4'b0010;
        in_data   = 32'h00005A00;
        cycle();
        out_ready = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        chk("rst_mid_valid", 32'(out_valid), 32'(0));
        chk("rst_mid_data", 32'(out_data), 32'(0));
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        cycle();
        chk("rst_rr_chan", 32'(out_channel), 32'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            mode      = ($urandom_range(0, 7) != 0) ? mode : ~mode;
            sel       = SW'($urandom);
            in_data   = $urandom;
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
